// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with occupancy count, programmable almost flags, registered
// read port with valid strobe, guarded push/pop and sticky overflow/underflow.
module fifo_sync_param #(
   parameter int width_adr  = 3,
   parameter int width_data = 288,
   parameter int af_level   = 6,
   parameter int ae_level   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [width_data-1:0] wr_dt,
   input  logic                  rd_en,
   output logic [width_data-1:0] rd_dt,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [width_adr:0]    count,
   output logic                  overflow,
   output logic                  underflow,
   output logic [width_adr:0]    d_wadr,
   output logic [width_adr:0]    d_radr
);

   localparam int depth = 1 << width_adr;
   localparam logic [width_adr:0] ptr_one  = (width_adr+1)'(1);
   localparam logic [width_adr:0] depth_lv = (width_adr+1)'(depth);
   localparam logic [width_adr:0] af_lv    = (width_adr+1)'(af_level);
   localparam logic [width_adr:0] ae_lv    = (width_adr+1)'(ae_level);

   if (af_level > depth || ae_level >= depth) begin : g_param_err
      $error("fifo_sync_param: af_level must be <= depth and ae_level < depth");
   end

   logic [width_data-1:0] mem_q [depth];
   logic [width_adr:0]    wptr_q, wptr_d;
   logic [width_adr:0]    rptr_q, rptr_d;
   logic [width_adr:0]    count_q, count_d;
   logic [width_data-1:0] rd_dt_q;
   logic                  rd_valid_q;
   logic                  ovf_q, unf_q;
   logic                  full_w, empty_w;
   logic                  wa, ra;

   // Flags come from registered pointers/count only; no path from wr_en/rd_en.
   assign empty_w = (wptr_q == rptr_q);
   assign full_w  = (wptr_q[width_adr-1:0] == rptr_q[width_adr-1:0]) &&
                    (wptr_q[width_adr] != rptr_q[width_adr]);

   assign wa = wr_en & ~full_w;
   assign ra = rd_en & ~empty_w;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wa) wptr_d = wptr_q + ptr_one;
      if (ra) rptr_d = rptr_q + ptr_one;
      case ({wa, ra})
         2'b10:   count_d = count_q + ptr_one;
         2'b01:   count_d = count_q - ptr_one;
         default: count_d = count_q;
      endcase
   end

   // Storage has no reset so it maps onto a plain 2-port RAM.
   always_ff @(posedge clk) begin
      if (!rst && wa) mem_q[wptr_q[width_adr-1:0]] <= wr_dt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         rd_dt_q    <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         rd_valid_q <= ra;
         if (ra) rd_dt_q <= mem_q[rptr_q[width_adr-1:0]];
         if (wr_en && full_w)  ovf_q <= 1'b1;
         if (rd_en && empty_w) unf_q <= 1'b1;
      end
   end

   assign rd_dt        = rd_dt_q;
   assign rd_valid     = rd_valid_q;
   assign full         = full_w;
   assign empty        = empty_w;
   assign almost_full  = (count_q >= af_lv);
   assign almost_empty = (count_q <= ae_lv);
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   assign d_wadr       = wptr_q;
   assign d_radr       = rptr_q;

   // depth_lv documents the full occupancy value; count never exceeds it.
   logic unused_depth;
   assign unused_depth = ^depth_lv;

endmodule
